// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer and full-flag generator for the dual-clock FIFO.
// Produces the binary BRAM write address, the registered Gray write pointer
// for the read domain, a conservative full flag and a sticky overflow flag.
// Optional macro FIFO_WR_LEVEL_EN adds a registered fill level (o_level) and
// an almost-full flag (o_almost_full) derived from the synchronized read pointer.
module fifo_wr_ptr_ctrl #(
  parameter int unsigned PTR_WIDTH          = 9,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned ALMOST_FULL_THRESH = 240
) (
  input  logic                 i_clk_wr,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [PTR_WIDTH-1:0] i_rd_ptr_gr,
  output logic                 o_full,
  output logic                 o_wr_ack,
  output logic [PTR_WIDTH-2:0] o_wr_ptr_bin,
  output logic [PTR_WIDTH-1:0] o_wr_ptr_gr,
  output logic                 o_overflow
`ifdef FIFO_WR_LEVEL_EN
  ,
  output logic [PTR_WIDTH-1:0] o_level,
  output logic                 o_almost_full
`endif
);

  logic [PTR_WIDTH-1:0] wr_bin_q, wr_bin_d;
  logic [PTR_WIDTH-1:0] wr_gr_q, wr_gr_d;
  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] rq_sync;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic                 full_q, full_d;
  logic                 overflow_q;
  logic                 wr_acc;

  // Write acceptance and next-pointer computation.
  always_comb begin
    wr_acc   = i_wr_en & ~full_q;
    wr_bin_d = wr_bin_q + PTR_WIDTH'(wr_acc);
    wr_gr_d  = wr_bin_d ^ (wr_bin_d >> 1);
    rq_sync  = sync_q[SYNC_STAGES-1];
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp = {~rq_sync[PTR_WIDTH-1:PTR_WIDTH-2], rq_sync[PTR_WIDTH-3:0]};
    full_d   = (wr_gr_d == full_cmp);
  end

  // Plain flop chain bringing the read-domain Gray pointer into this clock.
  always_ff @(posedge i_clk_wr) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_rd_ptr_gr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Pointer, full and sticky overflow state.
  always_ff @(posedge i_clk_wr) begin
    if (!i_rst_n) begin
      wr_bin_q   <= '0;
      wr_gr_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gr_q    <= wr_gr_d;
      full_q     <= full_d;
      overflow_q <= overflow_q | (i_wr_en & full_q);
    end
  end

  assign o_full       = full_q;
  assign o_wr_ack     = wr_acc;
  assign o_wr_ptr_bin = wr_bin_q[PTR_WIDTH-2:0];
  assign o_wr_ptr_gr  = wr_gr_q;
  assign o_overflow   = overflow_q;

`ifdef FIFO_WR_LEVEL_EN
  localparam logic [PTR_WIDTH:0] AfThresh = (PTR_WIDTH+1)'(ALMOST_FULL_THRESH);

  logic [PTR_WIDTH-1:0] rd_bin_sync;
  logic [PTR_WIDTH-1:0] level_d, level_q;
  logic                 almost_full_q;

  // Gray-to-binary of the synchronized read pointer and next fill level.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) rd_bin_sync[i] = ^(rq_sync >> i);
    level_d = wr_bin_d - rd_bin_sync;
  end

  // Level and almost-full registered with the same timing as the full flag.
  always_ff @(posedge i_clk_wr) begin
    if (!i_rst_n) begin
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      almost_full_q <= ({1'b0, level_d} >= AfThresh);
    end
  end

  assign o_level       = level_q;
  assign o_almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl (PTR_WIDTH=4, depth 8, SYNC_STAGES=2).
// Reference model tracks write/read counts as integers and derives full,
// level and pointers arithmetically.
module tb_fifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_gr;
  logic       full, wr_ack, overflow;
  logic [2:0] wr_bin;
  logic [3:0] wr_gr;
`ifdef FIFO_WR_LEVEL_EN
  logic [3:0] level;
  logic       almost_full;
`endif

  int tests = 0;
  int fails = 0;

  // Model state
  int         m_wr;
  int         m_lvl;
  logic       m_full, m_ovf;
  logic [3:0] m_h0, m_h1;

  always #5 clk = ~clk;

  fifo_wr_ptr_ctrl #(
    .PTR_WIDTH         (4),
    .SYNC_STAGES       (2),
    .ALMOST_FULL_THRESH(6)
  ) dut (
    .i_clk_wr     (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_rd_ptr_gr  (rd_gr),
    .o_full       (full),
    .o_wr_ack     (wr_ack),
    .o_wr_ptr_bin (wr_bin),
    .o_wr_ptr_gr  (wr_gr),
    .o_overflow   (overflow)
`ifdef FIFO_WR_LEVEL_EN
    ,
    .o_level      (level),
    .o_almost_full(almost_full)
`endif
  );

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v & 15);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_lvl = 0; m_full = 1'b0; m_ovf = 1'b0; m_h0 = '0; m_h1 = '0;
  endtask

  // One clock: drive inputs, check ack, step model, check registered outputs.
  task automatic cycle(input logic r, input logic w, input logic [3:0] rg);
    logic exp_ack;
    int   seen;
    rst_n = r; wr_en = w; rd_gr = rg;
    #1;
    exp_ack = w & ~m_full;
    chk("ack", {7'b0, wr_ack}, {7'b0, exp_ack});
    if (!r) begin
      model_reset();
    end else begin
      seen   = from_gray(m_h1);
      m_ovf  = m_ovf | (w & m_full);
      m_wr   = m_wr + int'(exp_ack);
      m_lvl  = (m_wr - seen) & 15;
      m_full = (m_lvl == 8);
      m_h1   = m_h0;
      m_h0   = rg;
    end
    @(posedge clk);
    #1;
    chk("wr_ptr_bin", {5'b0, wr_bin}, 8'(m_wr & 7));
    chk("wr_ptr_gr", {4'b0, wr_gr}, {4'b0, to_gray(m_wr)});
    chk("full", {7'b0, full}, {7'b0, m_full});
    chk("overflow", {7'b0, overflow}, {7'b0, m_ovf});
`ifdef FIFO_WR_LEVEL_EN
    chk("level", {4'b0, level}, 8'(m_lvl));
    chk("almost_full", {7'b0, almost_full}, {7'b0, m_lvl >= 6});
`endif
  endtask

  initial begin
    int   rd_cnt;
    logic wrap_seen, full_seen;
    logic [2:0] prev_bin;
    model_reset();
    rst_n = 1'b0; wr_en = 1'b1; rd_gr = '0;

    // 1: reset held for 3 edges with write requested
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'b0);
    chk("t1_full", {7'b0, full}, 8'd0);
    chk("t1_gr", {4'b0, wr_gr}, 8'd0);
    cycle(1'b1, 1'b0, 4'b0);
    chk("t1_full_rel", {7'b0, full}, 8'd0);

    // 2: fill with read pointer at 0, then two blocked requests
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'b0);
    chk("t2_full", {7'b0, full}, 8'd1);
    chk("t2_gr", {4'b0, wr_gr}, 8'b1100);
    chk("t2_ovf", {7'b0, overflow}, 8'd1);

    // 3: one read advance releases full exactly 3 edges later
    cycle(1'b1, 1'b0, 4'b0001);
    chk("t3_edge1", {7'b0, full}, 8'd1);
    cycle(1'b1, 1'b0, 4'b0001);
    chk("t3_edge2", {7'b0, full}, 8'd1);
    cycle(1'b1, 1'b0, 4'b0001);
    chk("t3_edge3", {7'b0, full}, 8'd0);
    cycle(1'b1, 1'b1, 4'b0001);
    chk("t3_gr", {4'b0, wr_gr}, 8'b1101);

    // 4: 20 writes with reader two behind
    cycle(1'b0, 1'b0, 4'b0);
    wrap_seen = 1'b0; full_seen = 1'b0; prev_bin = wr_bin;
    for (int i = 0; i < 20; i++) begin
      rd_cnt = (m_wr >= 2) ? m_wr - 2 : 0;
      cycle(1'b1, 1'b1, to_gray(rd_cnt));
      if (prev_bin == 3'd7 && wr_bin == 3'd0) wrap_seen = 1'b1;
      if (full) full_seen = 1'b1;
      prev_bin = wr_bin;
    end
    chk("t4_wrap", {7'b0, wrap_seen}, 8'd1);
    chk("t4_nofull", {7'b0, full_seen}, 8'd0);

    // 5: reset mid-burst
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, to_gray(m_wr));
    cycle(1'b0, 1'b1, 4'b0);
    chk("t5_bin", {5'b0, wr_bin}, 8'd0);
    chk("t5_gr", {4'b0, wr_gr}, 8'd0);
    chk("t5_full", {7'b0, full}, 8'd0);
    chk("t5_ovf", {7'b0, overflow}, 8'd0);

`ifdef FIFO_WR_LEVEL_EN
    // 6: level and almost-full
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 4'b0);
    chk("t6_level6", {4'b0, level}, 8'd6);
    chk("t6_af1", {7'b0, almost_full}, 8'd1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 4'b0011);
    chk("t6_level4", {4'b0, level}, 8'd4);
    chk("t6_af0", {7'b0, almost_full}, 8'd0);
    cycle(1'b0, 1'b0, 4'b0);
`endif

    // Random traffic: reader advances only behind accepted writes
    cycle(1'b0, 1'b0, 4'b0);
    rd_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, w;
      r = ($urandom_range(0, 99) != 0);
      w = ($urandom_range(0, 3) != 0);
      if (!r) rd_cnt = 0;
      else if (rd_cnt < m_wr && $urandom_range(0, 1) == 1) rd_cnt++;
      cycle(r, w, to_gray(rd_cnt));
      if (!r) rd_cnt = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
